// File: rtl/btb_assoc.sv
// btb_assoc: set-associative branch target buffer for the fetch stage.
//
// Lookup is combinational from stored state, so a same-cycle resolve to the
// same entry is not visible until the next cycle (read-before-write).
// Resolve updates, flush and RST all take effect on the rising edge of CLK.
// Replacement uses a tree pseudo-LRU per set.
//
// Optional feature macro: BTB_COUNTER_EN
//   defined   : per-entry 2-bit saturating direction counters.
//   undefined : no counter storage; every hit is predicted taken.
//
// Ports:
//   CLK            clock
//   RST            synchronous active-high reset (clears valid, PLRU, counters)
//   flush          invalidate all entries and PLRU state
//   pc_fetch       fetch PC (bits [1:0] ignored)
//   hit            valid tag match in the set of pc_fetch
//   predict_taken  hit and predicted taken
//   bt_fetch       target of the matching way, 0 on a miss
//   enable_res     resolve update strobe
//   pc_res         PC of the resolved branch
//   bt_res         resolved target
//   taken_res      resolved direction
module btb_assoc #(
    parameter int ENTRIES = 512,
    parameter int WAYS    = 2
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        flush,
    input  logic [31:0] pc_fetch,
    output logic        hit,
    output logic        predict_taken,
    output logic [31:0] bt_fetch,
    input  logic        enable_res,
    input  logic [31:0] pc_res,
    input  logic [31:0] bt_res,
    input  logic        taken_res
);

    localparam int SETS   = ENTRIES / WAYS;
    localparam int IDX_W  = $clog2(SETS);
    localparam int TAG_W  = 30 - IDX_W;
    localparam int WAY_W  = (WAYS > 1) ? $clog2(WAYS) : 1;
    localparam int PLRU_W = (WAYS > 1) ? WAYS - 1 : 1;

    logic [WAYS-1:0]   valid_mem [SETS];
    logic [TAG_W-1:0]  tag_mem   [SETS][WAYS];
    logic [31:0]       tgt_mem   [SETS][WAYS];
    logic [PLRU_W-1:0] plru_mem  [SETS];
`ifdef BTB_COUNTER_EN
    logic [1:0]        ctr_mem   [SETS][WAYS];
`endif

    // Tree PLRU helpers work on a 3-bit view (enough for 4 ways); each bit
    // points at the subtree holding the victim. Bit 0 is the root, bit 1 the
    // left pair (ways 0/1), bit 2 the right pair (ways 2/3).
    function automatic logic [1:0] plru_victim(input logic [2:0] b);
        logic [1:0] v;
        v = 2'd0;
        if (WAYS == 4)
            v = b[0] ? {1'b1, b[2]} : {1'b0, b[1]};
        else if (WAYS == 2)
            v = {1'b0, b[0]};
        return v;
    endfunction

    function automatic logic [2:0] plru_touch(input logic [2:0] b, input logic [1:0] w);
        logic [2:0] r;
        r = b;
        if (WAYS == 4) begin
            r[0] = ~w[1];
            if (w[1]) r[2] = ~w[0];
            else      r[1] = ~w[0];
        end else if (WAYS == 2) begin
            r[0] = ~w[0];
        end
        return r;
    endfunction

    logic [IDX_W-1:0] f_idx, r_idx;
    logic [TAG_W-1:0] f_tag, r_tag;
    logic             f_hit, r_hit, r_free;
    logic [WAY_W-1:0] f_way, r_way, r_free_way, r_victim, r_sel;
    logic [PLRU_W-1:0] plru_next;

    assign f_idx = pc_fetch[IDX_W+1:2];
    assign f_tag = pc_fetch[31:IDX_W+2];
    assign r_idx = pc_res[IDX_W+1:2];
    assign r_tag = pc_res[31:IDX_W+2];

    logic unused_pc_bits;
    assign unused_pc_bits = ^{pc_fetch[1:0], pc_res[1:0]};

    always_comb begin
        f_hit = 1'b0;
        f_way = '0;
        for (int w = 0; w < WAYS; w++) begin
            if (valid_mem[f_idx][w] && tag_mem[f_idx][w] == f_tag) begin
                f_hit = 1'b1;
                f_way = WAY_W'(w);
            end
        end
    end

    assign hit      = f_hit;
    assign bt_fetch = f_hit ? tgt_mem[f_idx][f_way] : 32'd0;
`ifdef BTB_COUNTER_EN
    assign predict_taken = f_hit & ctr_mem[f_idx][f_way][1];
`else
    assign predict_taken = f_hit;
`endif

    always_comb begin
        r_hit      = 1'b0;
        r_way      = '0;
        r_free     = 1'b0;
        r_free_way = '0;
        for (int w = 0; w < WAYS; w++) begin
            if (valid_mem[r_idx][w] && tag_mem[r_idx][w] == r_tag) begin
                r_hit = 1'b1;
                r_way = WAY_W'(w);
            end
        end
        // Descending scan so the lowest-index invalid way wins.
        for (int w = WAYS - 1; w >= 0; w--) begin
            if (!valid_mem[r_idx][w]) begin
                r_free     = 1'b1;
                r_free_way = WAY_W'(w);
            end
        end
        r_victim  = WAY_W'(plru_victim(3'(plru_mem[r_idx])));
        r_sel     = r_hit ? r_way : (r_free ? r_free_way : r_victim);
        plru_next = PLRU_W'(plru_touch(3'(plru_mem[r_idx]), 2'(r_sel)));
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            for (int s = 0; s < SETS; s++) begin
                valid_mem[s] <= '0;
                plru_mem[s]  <= '0;
`ifdef BTB_COUNTER_EN
                for (int w = 0; w < WAYS; w++) ctr_mem[s][w] <= 2'b00;
`endif
            end
        end else if (flush) begin
            for (int s = 0; s < SETS; s++) begin
                valid_mem[s] <= '0;
                plru_mem[s]  <= '0;
            end
        end else if (enable_res && (r_hit || taken_res)) begin
            plru_mem[r_idx] <= plru_next;
            if (r_hit) begin
                if (taken_res) tgt_mem[r_idx][r_way] <= bt_res;
`ifdef BTB_COUNTER_EN
                if (taken_res && ctr_mem[r_idx][r_way] != 2'b11)
                    ctr_mem[r_idx][r_way] <= ctr_mem[r_idx][r_way] + 2'b01;
                else if (!taken_res && ctr_mem[r_idx][r_way] != 2'b00)
                    ctr_mem[r_idx][r_way] <= ctr_mem[r_idx][r_way] - 2'b01;
`endif
            end else begin
                valid_mem[r_idx][r_sel] <= 1'b1;
                tag_mem[r_idx][r_sel]   <= r_tag;
                tgt_mem[r_idx][r_sel]   <= bt_res;
`ifdef BTB_COUNTER_EN
                ctr_mem[r_idx][r_sel]   <= 2'b10;
`endif
            end
        end
    end

endmodule

// File: tb/tb_btb_assoc.sv
module tb_btb_assoc;

    localparam int SETS = 256;
    localparam int WAYS = 2;
`ifdef BTB_COUNTER_EN
    localparam bit CTR_EN = 1'b1;
`else
    localparam bit CTR_EN = 1'b0;
`endif

    logic        CLK = 1'b0;
    logic        RST, flush, enable_res, taken_res;
    logic [31:0] pc_fetch, pc_res, bt_res;
    logic        hit, predict_taken;
    logic [31:0] bt_fetch;

    int checks = 0;
    int errors = 0;

    always #5 CLK = ~CLK;

    btb_assoc dut (
        .CLK(CLK), .RST(RST), .flush(flush), .pc_fetch(pc_fetch),
        .hit(hit), .predict_taken(predict_taken), .bt_fetch(bt_fetch),
        .enable_res(enable_res), .pc_res(pc_res), .bt_res(bt_res),
        .taken_res(taken_res)
    );

    // Reference model: each set is two ways plus the way that is currently
    // least recently used (for two ways the tree PLRU is exact LRU).
    bit          m_valid  [SETS][WAYS];
    logic [21:0] m_tag    [SETS][WAYS];
    logic [31:0] m_tgt    [SETS][WAYS];
    int          m_ctr    [SETS][WAYS];
    int          m_lru    [SETS];

    function automatic void m_clear(input bit full);
        for (int s = 0; s < SETS; s++) begin
            m_lru[s] = 0;
            for (int w = 0; w < WAYS; w++) begin
                m_valid[s][w] = 1'b0;
                if (full) m_ctr[s][w] = 0;
            end
        end
    endfunction

    function automatic void m_resolve(input logic [31:0] pc, input logic [31:0] bt, input bit tk);
        int s, hw, fw;
        s  = int'(pc[9:2]);
        hw = -1;
        fw = -1;
        for (int w = 0; w < WAYS; w++)
            if (m_valid[s][w] && m_tag[s][w] == pc[31:10]) hw = w;
        if (hw >= 0) begin
            if (tk) begin
                m_tgt[s][hw] = bt;
                if (m_ctr[s][hw] < 3) m_ctr[s][hw]++;
            end else if (m_ctr[s][hw] > 0) begin
                m_ctr[s][hw]--;
            end
            m_lru[s] = 1 - hw;
        end else if (tk) begin
            for (int w = WAYS - 1; w >= 0; w--) if (!m_valid[s][w]) fw = w;
            if (fw < 0) fw = m_lru[s];
            m_valid[s][fw] = 1'b1;
            m_tag[s][fw]   = pc[31:10];
            m_tgt[s][fw]   = bt;
            m_ctr[s][fw]   = 2;
            m_lru[s]       = 1 - fw;
        end
    endfunction

    function automatic void m_lookup(input logic [31:0] pc, output bit h, output bit p, output logic [31:0] t);
        int s;
        s = int'(pc[9:2]);
        h = 1'b0; p = 1'b0; t = 32'd0;
        for (int w = 0; w < WAYS; w++) begin
            if (m_valid[s][w] && m_tag[s][w] == pc[31:10]) begin
                h = 1'b1;
                t = m_tgt[s][w];
                p = CTR_EN ? (m_ctr[s][w] >= 2) : 1'b1;
            end
        end
    endfunction

    task automatic tick();
        @(posedge CLK);
        if (RST)             m_clear(1'b1);
        else if (flush)      m_clear(1'b0);
        else if (enable_res) m_resolve(pc_res, bt_res, taken_res);
        #1;
    endtask

    task automatic do_reset();
        RST = 1'b1; flush = 1'b0; enable_res = 1'b0;
        tick();
        RST = 1'b0;
    endtask

    task automatic resolve(input logic [31:0] pc, input logic [31:0] bt, input bit tk);
        enable_res = 1'b1; pc_res = pc; bt_res = bt; taken_res = tk;
        tick();
        enable_res = 1'b0;
    endtask

    task automatic test_reset();
        RST = 1'b1; flush = 1'b0; enable_res = 1'b0; taken_res = 1'b0;
        pc_res = 32'd0; bt_res = 32'd0; pc_fetch = 32'd0;
        tick(); tick();
        RST = 1'b0;
        for (int i = 0; i < 512; i++) begin
            pc_fetch = 32'(i * 4);
            @(negedge CLK);
            checks++;
            if (hit !== 1'b0 || bt_fetch !== 32'd0 || predict_taken !== 1'b0) begin
                errors++;
                $display("FAIL reset_sweep pc=%h: got hit=%b pt=%b bt=%h, expected 0/0/0",
                         pc_fetch, hit, predict_taken, bt_fetch);
            end
        end
    endtask

    task automatic test_basic();
        do_reset();
        resolve(32'h100, 32'h2000, 1'b1);
        pc_fetch = 32'h100;
        @(negedge CLK);
        checks++;
        if (hit !== 1'b1 || predict_taken !== 1'b1 || bt_fetch !== 32'h2000) begin
            errors++;
            $display("FAIL basic_hit: got hit=%b pt=%b bt=%h, expected 1/1/00002000",
                     hit, predict_taken, bt_fetch);
        end
        pc_fetch = 32'h500;
        @(negedge CLK);
        checks++;
        if (hit !== 1'b0 || bt_fetch !== 32'd0) begin
            errors++;
            $display("FAIL basic_tag_miss: got hit=%b bt=%h, expected 0/00000000", hit, bt_fetch);
        end
    endtask

    task automatic test_replacement();
        logic [31:0] pcs [3];
        logic [31:0] tgs [3];
        bit          exp_h [3];
        pcs = '{32'h000, 32'h400, 32'h800};
        tgs = '{32'hA0, 32'hA4, 32'hA8};
        do_reset();
        resolve(pcs[0], tgs[0], 1'b1);
        resolve(pcs[1], tgs[1], 1'b1);
        for (int k = 0; k < 2; k++) begin
            pc_fetch = pcs[k];
            @(negedge CLK);
            checks++;
            if (hit !== 1'b1 || bt_fetch !== tgs[k]) begin
                errors++;
                $display("FAIL repl_fill pc=%h: got hit=%b bt=%h, expected 1/%h",
                         pcs[k], hit, bt_fetch, tgs[k]);
            end
        end
        resolve(pcs[0], tgs[0], 1'b1);
        resolve(pcs[2], tgs[2], 1'b1);
        exp_h = '{1'b1, 1'b0, 1'b1};
        for (int k = 0; k < 3; k++) begin
            pc_fetch = pcs[k];
            @(negedge CLK);
            checks++;
            if (hit !== exp_h[k] || bt_fetch !== (exp_h[k] ? tgs[k] : 32'd0)) begin
                errors++;
                $display("FAIL repl_evict pc=%h: got hit=%b bt=%h, expected hit=%b",
                         pcs[k], hit, bt_fetch, exp_h[k]);
            end
        end
    endtask

    task automatic test_counter();
        bit exp_pt [3];
        // After: 1 not-taken; 1 taken; 3 not-taken + 1 taken.
        exp_pt = '{~CTR_EN, 1'b1, ~CTR_EN};
        do_reset();
        resolve(32'h100, 32'h2000, 1'b1);
        pc_fetch = 32'h100;
        for (int step = 0; step < 3; step++) begin
            if (step == 0) resolve(32'h100, 32'h2000, 1'b0);
            if (step == 1) resolve(32'h100, 32'h2000, 1'b1);
            if (step == 2) begin
                for (int n = 0; n < 3; n++) resolve(32'h100, 32'h2000, 1'b0);
                resolve(32'h100, 32'h2000, 1'b1);
            end
            @(negedge CLK);
            checks++;
            if (hit !== 1'b1 || predict_taken !== exp_pt[step]) begin
                errors++;
                $display("FAIL counter_step%0d: got hit=%b pt=%b, expected 1/%b",
                         step, hit, predict_taken, exp_pt[step]);
            end
        end
    endtask

    task automatic test_same_cycle();
        do_reset();
        resolve(32'h100, 32'h2000, 1'b1);
        pc_fetch = 32'h100;
        enable_res = 1'b1; pc_res = 32'h100; bt_res = 32'h3000; taken_res = 1'b1;
        @(negedge CLK);
        checks++;
        if (hit !== 1'b1 || bt_fetch !== 32'h2000) begin
            errors++;
            $display("FAIL same_cycle_old: got hit=%b bt=%h, expected 1/00002000", hit, bt_fetch);
        end
        tick();
        enable_res = 1'b0;
        @(negedge CLK);
        checks++;
        if (hit !== 1'b1 || bt_fetch !== 32'h3000) begin
            errors++;
            $display("FAIL same_cycle_new: got hit=%b bt=%h, expected 1/00003000", hit, bt_fetch);
        end
    endtask

    task automatic test_fill_clear(input bit use_rst);
        int bad_fill, bad_clear;
        do_reset();
        for (int i = 0; i < 512; i++) resolve(32'(i * 4), 32'(i), 1'b1);
        bad_fill = 0;
        for (int i = 0; i < 512; i++) begin
            pc_fetch = 32'(i * 4);
            @(negedge CLK);
            if (hit !== 1'b1 || bt_fetch !== 32'(i)) bad_fill++;
        end
        checks++;
        if (bad_fill != 0) begin
            errors++;
            $display("FAIL fill_all rst=%0d: got %0d wrong lookups, expected 0", use_rst, bad_fill);
        end
        enable_res = 1'b1; pc_res = 32'h1234_5678; bt_res = 32'hDEAD; taken_res = 1'b1;
        if (use_rst) RST = 1'b1; else flush = 1'b1;
        tick();
        RST = 1'b0; flush = 1'b0; enable_res = 1'b0;
        bad_clear = 0;
        for (int i = 0; i <= 512; i++) begin
            pc_fetch = (i == 512) ? 32'h1234_5678 : 32'(i * 4);
            @(negedge CLK);
            if (hit !== 1'b0 || predict_taken !== 1'b0 || bt_fetch !== 32'd0) bad_clear++;
        end
        checks++;
        if (bad_clear != 0) begin
            errors++;
            $display("FAIL clear_all rst=%0d: got %0d lookups still hitting, expected 0",
                     use_rst, bad_clear);
        end
    endtask

    task automatic test_random();
        bit          eh, ep;
        logic [31:0] et;
        do_reset();
        for (int c = 0; c < 3000; c++) begin
            pc_fetch   = {20'($urandom_range(0, 3)), 8'($urandom_range(0, 3)), 2'($urandom_range(0, 3)), 2'b00} ;
            pc_fetch   = {pc_fetch[31:10] & 22'h3, pc_fetch[9:0]};
            pc_res     = {30'({$urandom_range(0, 3), 8'($urandom_range(0, 3))}), 2'b00};
            bt_res     = $urandom;
            taken_res  = ($urandom_range(0, 9) < 7);
            enable_res = ($urandom_range(0, 9) < 7);
            flush      = ($urandom_range(0, 149) == 0);
            RST        = ($urandom_range(0, 299) == 0);
            @(negedge CLK);
            m_lookup(pc_fetch, eh, ep, et);
            checks++;
            if (hit !== eh || predict_taken !== ep || bt_fetch !== et) begin
                errors++;
                $display("FAIL random c=%0d pc=%h: got hit=%b pt=%b bt=%h, expected %b/%b/%h",
                         c, pc_fetch, hit, predict_taken, bt_fetch, eh, ep, et);
            end
            tick();
        end
        RST = 1'b0; flush = 1'b0; enable_res = 1'b0;
    endtask

    initial begin
        m_clear(1'b1);
        test_reset();
        test_basic();
        test_replacement();
        test_counter();
        test_same_cycle();
        test_fill_clear(1'b0);
        test_fill_clear(1'b1);
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/btb_assoc.md
# btb_assoc

Parametrised set-associative branch target buffer for the fetch stage. It holds taken-branch targets indexed by word-aligned PC, with configurable depth and associativity. Tree pseudo-LRU replacement and per-entry 2-bit direction counters replace the direct-mapped, always-taken behaviour of the previous BTB. Fetch lookup is combinational from stored state. Resolve updates from execute commit on the rising edge.

## Interface
Parameters:
- ENTRIES, 512, total entries; power of two, at least WAYS.
- WAYS, 2, associativity; one of 1, 2, 4.
- Derived: SETS = ENTRIES/WAYS; IDX_W = log2(SETS); TAG_W = 30 - IDX_W.

Ports:
- CLK  in  1  clock; all state updates on rising edge.
- RST  in  1  reset, synchronous, active-high.
- flush  in  1  invalidate all entries.
- pc_fetch  in  32  fetch PC; bits [1:0] ignored.
- hit  out  1  valid tag match in set of pc_fetch.
- predict_taken  out  1  hit AND predicted taken.
- bt_fetch  out  32  target of matching way; 0 when hit=0.
- enable_res  in  1  resolve update strobe, one update per cycle.
- pc_res  in  32  PC of resolved branch.
- bt_res  in  32  resolved target.
- taken_res  in  1  resolved direction.

## Operation
- Index = pc[IDX_W+1:2]; tag = pc[31:IDX_W+2]. Each way stores valid, tag, target[31:0] and ctr[1:0].
- Lookup (combinational): hit = OR over ways of (valid & tag match). At most one way matches by construction. predict_taken = hit & ctr[1].
- Resolve with enable_res=1, hit in pc_res set:
  - Taken: target <= bt_res; ctr increments, saturating at 3.
  - Not taken: ctr decrements, saturating at 0; target unchanged. The entry stays valid.
  - Either direction: PLRU is updated to mark the way most-recent.
- Resolve with enable_res=1, miss, taken_res=1:
  - Allocate the lowest-index invalid way; if none, the PLRU victim.
  - Write valid=1, tag, target=bt_res, ctr=2'b10. Mark the way most-recent.
- Resolve with enable_res=1, miss, taken_res=0: no state change.
- PLRU: WAYS-1 bits per set, tree form. WAYS=1 has no bits and always selects way 0. For WAYS=2, bit=0 selects way 0 as victim. Fetch lookups never modify PLRU.
- flush: clears all valid bits and PLRU bits. Takes priority over a same-cycle resolve, which is dropped.
- RST: same effect as flush, plus all ctr cleared to 0. Tags and targets are don't-care.

## Timing
- Lookup latency is 0 cycles; outputs follow pc_fetch in the same cycle.
- Resolve, flush and RST take effect at the edge where they are sampled. Results are visible to lookup from the next cycle.
- Same-cycle fetch and resolve to the same entry: the fetch sees pre-update contents (read-before-write).
- Outputs in the cycle after RST or flush: hit=0, predict_taken=0, bt_fetch=0, for any pc_fetch.
- RST asserted mid-stream overrides flush and resolve; state is fully reset in one cycle.
- No backpressure: enable_res is an unconditional one-cycle pulse per resolved branch.

## Configuration
- BTB_COUNTER_EN defined:
  - 2-bit saturating counters are implemented as above.
  - Not-taken resolves train the entry down.
- BTB_COUNTER_EN undefined:
  - No ctr storage; predict_taken = hit.
  - Not-taken resolves on a hit change only PLRU.
  - Allocation behaviour is unchanged.

## Test plan
Defaults: ENTRIES=512, WAYS=2, so IDX_W=8 and tag is pc[31:10].

1. RST, then sweep pc_fetch 0x0 to 0x7FC -> hit=0, bt_fetch=0 throughout.
2. Resolve pc_res=0x100, bt_res=0x2000, taken=1; next cycle pc_fetch=0x100 -> hit=1, predict_taken=1, bt_fetch=0x2000. Then pc_fetch=0x500 (same set, different tag) -> hit=0.
3. Replacement:
   - Resolve taken 0x000 then 0x400 (same set, both ways filled); both hit.
   - Resolve taken 0x000 again (marks way 0 most-recent), then taken 0x800 -> 0x400 is evicted; 0x000 and 0x800 hit, 0x400 misses.
4. Counter training (BTB_COUNTER_EN):
   - Allocate 0x100 (ctr=2), resolve not-taken once -> predict_taken=0, hit=1.
   - Taken once -> predict_taken=1.
   - Three not-taken then one taken -> predict_taken=0 (saturated at 0, now 1).
   - Without the macro, predict_taken stays 1 throughout.
5. Same-cycle resolve taken 0x100 to 0x3000 and fetch 0x100, with an old entry whose target is 0x2000 -> that cycle shows bt_fetch=0x2000; next cycle shows 0x3000.
6. Fill all 512 entries (pc=4·i, target=i, i<512), then assert flush together with enable_res -> all lookups miss next cycle and the dropped resolve is not installed. Repeat the fill using RST -> same result.
